// File: rtl/main_sys_pkg.sv
// main_sys_pkg: shared FSM encodings and default timeout for the APB initiator.
//   Contents: apb_state_e (2-bit state encoding), DEFAULT_TIMEOUT.
package main_sys_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;
    localparam int unsigned DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/apb_wdog_cnt.sv
// apb_wdog_cnt: saturating watchdog counter for APB ACCESS-phase wait cycles.
//   clk_i/rst_i : clock, synchronous active-high reset
//   clear_i     : zero the count (transaction start)
//   enable_i    : count one stalled ACCESS cycle
//   expired_o   : count sits on the abort threshold (P_TIMEOUT-1); never set when P_TIMEOUT=0
module apb_wdog_cnt
    import main_sys_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    // A zero timeout still needs a one-bit register to stay legal.
    localparam int unsigned W = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] MAX = W'(P_TIMEOUT);
    localparam logic [W-1:0] THR = (P_TIMEOUT > 0) ? W'(P_TIMEOUT - 1) : '0;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clear_i ? '0 : (enable_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = (P_TIMEOUT != 0) && (cnt_q == THR);
endmodule

// File: rtl/main_apb_init.sv
// main_apb_init: single-outstanding APB3 initiator bridging a valid/ready command
// channel to APB, with a response channel and an ACCESS-phase watchdog.
//   i_clk_main_system / i_rst_main_system : clock, synchronous active-high reset
//   i_req_* / o_req_ready                 : command request (write, addr, wdata)
//   o_rsp_* / i_rsp_ready                 : response (rdata, err, timeout)
//   o_p* / i_p*                           : APB3 initiator interface
//   o_busy                                : transaction in flight (state not IDLE)
module main_apb_init
    import main_sys_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        i_clk_main_system,
    input  logic        i_rst_main_system,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_paddr,
    output logic [31:0] o_pwdata,
    input  logic [31:0] i_prdata,
    input  logic        i_pready,
    input  logic        i_pslverr,
    output logic        o_busy
);
    apb_state_e  state_q, state_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic        wd_clear, wd_enable, wd_expired;

    apb_wdog_cnt #(.P_TIMEOUT(P_TIMEOUT)) u_wdog (
        .clk_i    (i_clk_main_system),
        .rst_i    (i_rst_main_system),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        wd_clear  = 1'b0;
        wd_enable = (state_q == ST_ACCESS) && !i_pready;
        case (state_q)
            ST_IDLE: if (i_req_valid) begin
                state_d  = ST_SETUP;
                pwrite_d = i_req_write;
                paddr_d  = i_req_addr;
                pwdata_d = i_req_wdata;
                wd_clear = 1'b1;
            end
            ST_SETUP: state_d = ST_ACCESS;
            // pready wins over a watchdog expiry in the same cycle.
            ST_ACCESS: if (i_pready) begin
                state_d = ST_RESP;
                rdata_d = pwrite_q ? 32'h0 : i_prdata;
                err_d   = i_pslverr;
                tmo_d   = 1'b0;
            end else if (wd_expired) begin
                state_d = ST_RESP;
                rdata_d = 32'h0;
                err_d   = 1'b1;
                tmo_d   = 1'b1;
            end
            ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_main_system) begin
        if (i_rst_main_system) begin
            state_q  <= ST_IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    // Held low during reset so nothing upstream sees a ready it cannot use.
    assign o_req_ready   = (state_q == ST_IDLE) && !i_rst_main_system;
    assign o_psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign o_penable     = (state_q == ST_ACCESS);
    assign o_pwrite      = pwrite_q;
    assign o_paddr       = paddr_q;
    assign o_pwdata      = pwdata_q;
    assign o_rsp_valid   = (state_q == ST_RESP);
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_err     = err_q;
    assign o_rsp_timeout = tmo_q;
    assign o_busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_main_apb_init.sv
// tb_main_apb_init: scoreboard bench for main_apb_init with a 4-cycle watchdog.
module tb_main_apb_init;
    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;
    logic        o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout;
    logic        o_psel, o_penable, o_pwrite, o_busy;
    logic [31:0] o_rsp_rdata, o_paddr, o_pwdata;

    rsp_t exp_q[$];
    int   vec = 0;
    int   mis = 0;

    main_apb_init #(.P_TIMEOUT(TMO)) dut (
        .i_clk_main_system(clk),
        .i_rst_main_system(rst),
        .i_req_valid      (req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_write      (req_write),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_rdata      (o_rsp_rdata),
        .o_rsp_err        (o_rsp_err),
        .o_rsp_timeout    (o_rsp_timeout),
        .o_psel           (o_psel),
        .o_penable        (o_penable),
        .o_pwrite         (o_pwrite),
        .o_paddr          (o_paddr),
        .o_pwdata         (o_pwdata),
        .i_prdata         (prdata),
        .i_pready         (pready),
        .i_pslverr        (pslverr),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: nwait ACCESS cycles with pready low before completion
    // (nwait >= TMO means the watchdog fires), then rsp_hold cycles of response backpressure.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input logic slv, input int nwait, input int rsp_hold);
        bit   tmo;
        int   nacc;
        rsp_t got;
        rsp_t e;
        tmo  = (nwait >= TMO);
        nacc = tmo ? TMO : nwait + 1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        vec++;
        if (o_req_ready !== 1'b1) begin
            mis++; $display("FAIL req_ready_idle: got %b exp 1", o_req_ready);
        end
        exp_q.push_back(tmo ? rsp_t'{32'h0, 1'b1, 1'b1} : rsp_t'{wr ? 32'h0 : rd, slv, 1'b0});
        tick;
        req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
        vec++;
        if ({o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid, o_busy, o_req_ready}
            !== {1'b1, 1'b0, wr, addr, wdata, 1'b0, 1'b1, 1'b0}) begin
            mis++; $display("FAIL setup: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h exp psel=1 pen=0 pw=%b paddr=%h pwdata=%h",
                            o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, wr, addr, wdata);
        end
        tick;
        for (int k = 0; k < nacc; k++) begin
            pready  = (k >= nwait);
            prdata  = (k >= nwait) ? rd : $urandom;
            pslverr = (k >= nwait) ? slv : 1'($urandom);
            vec++;
            if ({o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid}
                !== {1'b1, 1'b1, wr, addr, wdata, 1'b0}) begin
                mis++; $display("FAIL access[%0d]: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h rv=%b exp 1 1 %b %h %h 0",
                                k, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid, wr, addr, wdata);
            end
            tick;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        req_valid = 1'b1; req_addr = $urandom;
        for (int k = 0; k <= rsp_hold; k++) begin
            rsp_ready = (k == rsp_hold);
            got = {o_rsp_rdata, o_rsp_err, o_rsp_timeout};
            vec++;
            if (k == rsp_hold) e = exp_q.pop_front(); else e = exp_q[0];
            if ({o_rsp_valid, o_psel, o_penable, o_req_ready, o_busy, got}
                !== {5'b10001, e}) begin
                mis++; $display("FAIL resp[%0d]: got rv=%b psel=%b pen=%b rdy=%b busy=%b rdata=%h err=%b tmo=%b exp 1 0 0 0 1 rdata=%h err=%b tmo=%b",
                                k, o_rsp_valid, o_psel, o_penable, o_req_ready, o_busy, got.rdata, got.err, got.tmo,
                                e.rdata, e.err, e.tmo);
            end
            tick;
        end
        rsp_ready = 1'b0; req_valid = 1'b0;
        vec++;
        if ({o_rsp_valid, o_req_ready, o_busy, o_psel} !== 4'b0100) begin
            mis++; $display("FAIL post_resp_idle: got rv=%b rdy=%b busy=%b psel=%b exp 0 1 0 0",
                            o_rsp_valid, o_req_ready, o_busy, o_psel);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        vec++;
        if ({o_req_ready, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid,
             o_rsp_rdata, o_rsp_err, o_rsp_timeout, o_busy} !== '0) begin
            mis++; $display("FAIL reset_state: got rdy=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h rv=%b rdata=%h err=%b tmo=%b busy=%b exp all 0",
                            o_req_ready, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid,
                            o_rsp_rdata, o_rsp_err, o_rsp_timeout, o_busy);
        end
        rst = 1'b0;
        #1;
        vec++;
        if (o_req_ready !== 1'b1) begin
            mis++; $display("FAIL reset_release_ready: got %b exp 1", o_req_ready);
        end
    endtask

    task automatic test_write;
        run_txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0, 0, 0);
    endtask

    task automatic test_read_wait;
        run_txn(1'b0, 32'h1000_0008, 32'h0, 32'h1234_5678, 1'b0, 3, 0);
    endtask

    task automatic test_slverr;
        run_txn(1'b0, 32'h2000_0010, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 0);
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 32'h3000_0000, 32'h0, 32'h5555_5555, 1'b0, 20, 0);
        run_txn(1'b1, 32'h3000_0004, 32'h0BAD_F00D, 32'h7777_7777, 1'b0, 3, 0);
        run_txn(1'b1, 32'h3000_0008, 32'h1, 32'h0, 1'b0, TMO, 1);
    endtask

    task automatic test_rsp_backpressure;
        run_txn(1'b0, 32'h4000_0000, 32'h0, 32'hA5A5_5A5A, 1'b0, 1, 5);
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h5000_0000;
        tick;
        req_valid = 1'b0;
        tick;
        pready = 1'b0;
        vec++;
        if ({o_psel, o_penable} !== 2'b11) begin
            mis++; $display("FAIL rst_mid_access_pre: got psel=%b pen=%b exp 1 1", o_psel, o_penable);
        end
        rst = 1'b1;
        tick;
        vec++;
        if ({o_psel, o_penable, o_rsp_valid, o_req_ready, o_busy, o_paddr} !== '0) begin
            mis++; $display("FAIL rst_mid_access: got psel=%b pen=%b rv=%b rdy=%b busy=%b paddr=%h exp all 0",
                            o_psel, o_penable, o_rsp_valid, o_req_ready, o_busy, o_paddr);
        end
        rst = 1'b0;
        pready = 1'b1; prdata = 32'h1111_2222;
        #1;
        vec++;
        if (o_req_ready !== 1'b1) begin
            mis++; $display("FAIL rst_mid_release_ready: got %b exp 1", o_req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            vec++;
            if ({o_rsp_valid, o_psel} !== 2'b00) begin
                mis++; $display("FAIL rst_mid_no_rsp[%0d]: got rv=%b psel=%b exp 0 0", k, o_rsp_valid, o_psel);
            end
        end
        pready = 1'b0;
        run_txn(1'b0, 32'h5000_0004, 32'h0, 32'h3333_4444, 1'b0, 2, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++)
            run_txn(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_rsp_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
